// File: rtl/ula_acc_stage.sv
// ALU result stage: accumulator register plus a small in-order output buffer.
// Optional ULA_ACC_FLAGS_EN stores the opcode per entry and drives out_zero/out_neg.
module ula_acc_stage #(
    parameter int NUBITS = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               op,
    input  logic signed [NUBITS-1:0] ula_out,
    input  logic                     acc_we,
    output logic signed [NUBITS-1:0] acc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUBITS-1:0]        out_data,
    output logic                     out_cmp,
    output logic                     out_zero,
    output logic                     out_neg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH != 2 && DEPTH != 4) begin : g_depth_chk
        $error("ula_acc_stage: DEPTH must be 2 or 4");
    end

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [NUBITS-1:0] acc_q, acc_d;
    logic [NUBITS-1:0] data_mem_q [DEPTH];
    logic [NUBITS-1:0] wr_data;
    logic [NUBITS-1:0] head_data;
    logic              push, pop, in_is_cmp, head_is_cmp;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign in_is_cmp = (op == 5'd13) || (op == 5'd14) || (op == 5'd15);
    // Compare ops only carry a meaningful bit 0; the rest of the word is dropped.
    assign wr_data   = in_is_cmp ? {{(NUBITS-1){1'b0}}, ula_out[0]} : ula_out;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        acc_d = (push && acc_we) ? wr_data : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            acc_q    <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) data_mem_q[wr_ptr_q] <= wr_data;
    end

    assign head_data = data_mem_q[rd_ptr_q];
    assign out_data  = head_data;
    assign acc       = acc_q;

`ifdef ULA_ACC_FLAGS_EN
    logic [4:0] op_mem_q [DEPTH];
    logic [4:0] head_op;

    always_ff @(posedge clk) begin
        if (push) op_mem_q[wr_ptr_q] <= op;
    end

    assign head_op     = op_mem_q[rd_ptr_q];
    assign head_is_cmp = (head_op == 5'd13) || (head_op == 5'd14) || (head_op == 5'd15);
    assign out_zero    = out_valid && (head_data == '0);
    assign out_neg     = out_valid && head_data[NUBITS-1];
`else
    logic cmp_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) cmp_mem_q[wr_ptr_q] <= in_is_cmp;
    end

    assign head_is_cmp = cmp_mem_q[rd_ptr_q];
    assign out_zero    = 1'b0;
    assign out_neg     = 1'b0;
`endif

    assign out_cmp = out_valid && head_is_cmp && head_data[0];

endmodule

// File: tb/tb_ula_acc_stage.sv
// Directed vector bench for ula_acc_stage (DEPTH=2, NUBITS=32).
module tb_ula_acc_stage;

`ifdef ULA_ACC_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, acc_we, out_valid, out_ready;
    logic [4:0]  op;
    logic signed [31:0] ula_out, acc;
    logic [31:0] out_data;
    logic        out_cmp, out_zero, out_neg;

    int checks = 0;
    int errors = 0;

    ula_acc_stage #(.NUBITS(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ula_out(ula_out), .acc_we(acc_we), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cmp(out_cmp), .out_zero(out_zero), .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  op;
        logic [31:0] d;
        logic        we;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_data;
        logic [31:0] e_acc;
        logic        e_cmp;
        logic        e_zero;
        logic        e_neg;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] o, input logic [31:0] d,
                         input logic we, input logic ordy);
        in_valid  = iv;
        op        = o;
        ula_out   = d;
        acc_we    = we;
        out_ready = ordy;
    endtask

    initial begin
        //          iv op     data          we ordy ir ov data          acc           cmp zero neg
        vecs[0]  = '{1, 5'd0,  32'd5,        1, 1,  1, 1, 32'd5,        32'd5,        0, 0, 0};
        vecs[1]  = '{0, 5'd0,  32'd0,        0, 1,  1, 0, 32'd0,        32'd5,        0, 0, 0};
        vecs[2]  = '{1, 5'd0,  32'd1,        0, 0,  1, 1, 32'd1,        32'd5,        0, 0, 0};
        vecs[3]  = '{1, 5'd0,  32'd2,        0, 0,  0, 1, 32'd1,        32'd5,        0, 0, 0};
        vecs[4]  = '{1, 5'd0,  32'd3,        1, 0,  0, 1, 32'd1,        32'd5,        0, 0, 0};
        vecs[5]  = '{0, 5'd0,  32'd0,        0, 1,  1, 1, 32'd2,        32'd5,        0, 0, 0};
        vecs[6]  = '{0, 5'd0,  32'd0,        0, 1,  1, 0, 32'd0,        32'd5,        0, 0, 0};
        vecs[7]  = '{1, 5'd0,  32'd10,       0, 0,  1, 1, 32'd10,       32'd5,        0, 0, 0};
        vecs[8]  = '{1, 5'd0,  32'd11,       0, 0,  0, 1, 32'd10,       32'd5,        0, 0, 0};
        vecs[9]  = '{1, 5'd0,  32'd12,       1, 1,  1, 1, 32'd11,       32'd5,        0, 0, 0};
        vecs[10] = '{1, 5'd0,  32'd20,       0, 1,  1, 1, 32'd20,       32'd5,        0, 0, 0};
        vecs[11] = '{0, 5'd0,  32'd0,        0, 1,  1, 0, 32'd0,        32'd5,        0, 0, 0};
        vecs[12] = '{1, 5'd14, 32'hFFFFFFFF, 1, 0,  1, 1, 32'd1,        32'd1,        1, 0, 0};
        vecs[13] = '{1, 5'd13, 32'hFFFFFFFE, 0, 1,  1, 1, 32'd0,        32'd1,        0, 1, 0};
        vecs[14] = '{1, 5'd0,  32'hFFFFFFF9, 1, 1,  1, 1, 32'hFFFFFFF9, 32'hFFFFFFF9, 0, 0, 1};
        vecs[15] = '{1, 5'd0,  32'd0,        0, 1,  1, 1, 32'd0,        32'hFFFFFFF9, 0, 1, 0};
        vecs[16] = '{1, 5'd15, 32'd3,        1, 1,  1, 1, 32'd1,        32'd1,        1, 0, 0};
        vecs[17] = '{1, 5'd12, 32'h80000001, 0, 1,  1, 1, 32'h80000001, 32'd1,        0, 0, 1};
        vecs[18] = '{0, 5'd0,  32'd0,        1, 1,  1, 0, 32'd0,        32'd1,        0, 0, 0};

        rst = 1'b1;
        drive(0, 5'd0, 32'd0, 0, 0);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_acc",       acc,            32'd0);
        chk("rst_out_cmp",   32'(out_cmp),   32'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].op, vecs[i].d, vecs[i].we, vecs[i].ordy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_acc", i),       acc,            vecs[i].e_acc);
            chk($sformatf("v%0d_out_cmp", i),   32'(out_cmp),   32'(vecs[i].e_cmp));
            chk($sformatf("v%0d_out_zero", i),  32'(out_zero),  32'(vecs[i].e_zero & FLAGS));
            chk($sformatf("v%0d_out_neg", i),   32'(out_neg),   32'(vecs[i].e_neg & FLAGS));
            if (vecs[i].e_ov)
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
        end

        // Fill the buffer, then reset mid-transfer and look before any edge.
        @(negedge clk);
        drive(1, 5'd0, 32'hAA, 1, 0);
        @(negedge clk);
        drive(1, 5'd0, 32'hBB, 0, 0);
        @(negedge clk);
        drive(0, 5'd0, 32'd0, 0, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head",     out_data,      32'hAA);
        chk("full_acc",      acc,           32'hAA);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acc",       acc,            32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);

        @(negedge clk);
        rst = 1'b0;
        drive(1, 5'd0, 32'h77, 1, 0);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data",      out_data,       32'h77);
        chk("post_rst_acc",       acc,            32'h77);
        chk("post_rst_in_ready",  32'(in_ready),  32'd1);

        @(negedge clk);
        drive(1, 5'd0, 32'h88, 0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_full",  32'(in_ready), 32'd0);
        chk("post_rst_head",  out_data,      32'h77);

        @(negedge clk);
        drive(0, 5'd0, 32'd0, 0, 1);
        @(posedge clk);
        #1;
        chk("post_rst_second", out_data, 32'h88);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
